// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// mem_access : memory-access / retire stage (loads, stores, writeback, fetch
//              redirect). Define CALL_STACK_EN to build the CALL/RET stack.
// Revision   : 1.0
// ============================================================================
module mem_access #(
  parameter int STACK_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic [31:0] ALU_IN,
  input  logic [4:0]  OPCD_IN,
  input  logic [4:0]  ADDR_REG_IN,
  input  logic        OPT_BIT_IN,
  input  logic        COND_IN,
  input  logic [15:0] NPC_IN,
  input  logic [15:0] STORE_DATA,
  output logic        BUSY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        WB_EN,
  output logic [4:0]  WB_ADDR,
  output logic [15:0] WB_DATA,
  output logic        PC_LOAD,
  output logic [15:0] PC_TARGET,
  output logic        DONE,
  output logic        STACK_ERR,
  output logic [2:0]  ESTADO
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISPATCH  = 3'd1,
    MEM_RD    = 3'd2,
    MEM_WR    = 3'd3,
    WRITEBACK = 3'd4,
    REDIRECT  = 3'd5,
    FINISH    = 3'd6
  } state_t;

  localparam logic [4:0] OP_LW   = 5'd0;
  localparam logic [4:0] OP_SW   = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_DIV  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd9;
  localparam logic [4:0] OP_JR   = 5'd10;
  localparam logic [4:0] OP_JPC  = 5'd11;
  localparam logic [4:0] OP_BRLF = 5'd12;
  localparam logic [4:0] OP_CALL = 5'd13;
  localparam logic [4:0] OP_RET  = 5'd14;

  state_t      state_q, state_d;
  logic [15:0] alu_q, alu_d;
  logic [4:0]  opcd_q, opcd_d;
  logic [4:0]  addr_q, addr_d;
  logic        opt_q, opt_d;
  logic        cond_q, cond_d;
  logic [15:0] npc_q, npc_d;
  logic [15:0] sdata_q, sdata_d;

  logic        busy_q, busy_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        pc_load_q, pc_load_d;
  logic [15:0] pc_target_q, pc_target_d;
  logic        done_q, done_d;

`ifdef CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH) + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] sp_dec;
  logic           stack_err_q, stack_err_d;
  logic           push_en;
  logic [15:0]    stack_q [STACK_DEPTH];
  logic [15:0]    stack_d [STACK_DEPTH];

  assign sp_dec = sp_q - SPW'(1);

  always_comb begin
    stack_d = stack_q;
    if (push_en) stack_d[sp_q[SPW-2:0]] = npc_q;
  end
`endif

  always_comb begin
    state_d     = state_q;
    alu_d       = alu_q;
    opcd_d      = opcd_q;
    addr_d      = addr_q;
    opt_d       = opt_q;
    cond_d      = cond_q;
    npc_d       = npc_q;
    sdata_d     = sdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    wb_en_d     = 1'b0;
    wb_addr_d   = '0;
    wb_data_d   = '0;
    pc_load_d   = 1'b0;
    pc_target_d = '0;
    done_d      = 1'b0;
`ifdef CALL_STACK_EN
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    push_en     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          alu_d   = ALU_IN[15:0];
          opcd_d  = OPCD_IN;
          addr_d  = ADDR_REG_IN;
          opt_d   = OPT_BIT_IN;
          npc_d   = NPC_IN;
          sdata_d = STORE_DATA;
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        cond_d = COND_IN;
        case (opcd_q)
          OP_LW: state_d = MEM_RD;
          OP_SW: state_d = MEM_WR;
          OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT: begin
            state_d   = WRITEBACK;
            wb_data_d = alu_q;
          end
          OP_JR, OP_JPC, OP_BRLF: begin
            if (COND_IN) begin
              state_d     = REDIRECT;
              pc_target_d = alu_q;
            end else begin
              state_d = FINISH;
            end
          end
`ifdef CALL_STACK_EN
          OP_CALL: begin
            // A full stack drops the push but the call still redirects.
            state_d     = REDIRECT;
            pc_target_d = alu_q;
            if (sp_q == SP_FULL) begin
              stack_err_d = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SPW'(1);
            end
          end
          OP_RET: begin
            state_d = REDIRECT;
            if (sp_q == '0) begin
              stack_err_d = 1'b1;
            end else begin
              sp_d        = sp_dec;
              pc_target_d = stack_q[sp_dec[SPW-2:0]];
            end
          end
`else
          OP_CALL: begin
            state_d     = REDIRECT;
            pc_target_d = alu_q;
          end
          OP_RET: state_d = FINISH;
`endif
          default: state_d = FINISH;
        endcase
      end
      MEM_RD: begin
        if (MEM_ACK) begin
          state_d   = WRITEBACK;
          wb_data_d = MEM_RDATA;
        end
      end
      MEM_WR: begin
        if (MEM_ACK) state_d = FINISH;
      end
      WRITEBACK, REDIRECT, FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Moore outputs are decoded from the state being entered so they register with it.
    busy_d = (state_d != IDLE);
    case (state_d)
      MEM_RD: begin
        mem_req_d  = 1'b1;
        mem_addr_d = alu_q;
      end
      MEM_WR: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = alu_q;
        mem_wdata_d = sdata_q;
      end
      WRITEBACK: begin
        wb_en_d   = 1'b1;
        wb_addr_d = addr_q;
        done_d    = 1'b1;
      end
      REDIRECT: begin
        pc_load_d = 1'b1;
        done_d    = 1'b1;
      end
      FINISH:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      alu_q       <= '0;
      opcd_q      <= '0;
      addr_q      <= '0;
      opt_q       <= 1'b0;
      cond_q      <= 1'b0;
      npc_q       <= '0;
      sdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      done_q      <= 1'b0;
`ifdef CALL_STACK_EN
      sp_q        <= '0;
      stack_err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      alu_q       <= alu_d;
      opcd_q      <= opcd_d;
      addr_q      <= addr_d;
      opt_q       <= opt_d;
      cond_q      <= cond_d;
      npc_q       <= npc_d;
      sdata_q     <= sdata_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      done_q      <= done_d;
`ifdef CALL_STACK_EN
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
      stack_q     <= stack_d;
`endif
    end
  end

  assign BUSY      = busy_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign WB_EN     = wb_en_q;
  assign WB_ADDR   = wb_addr_q;
  assign WB_DATA   = wb_data_q;
  assign PC_LOAD   = pc_load_q;
  assign PC_TARGET = pc_target_q;
  assign DONE      = done_q;
  assign ESTADO    = state_q;
`ifdef CALL_STACK_EN
  assign STACK_ERR = stack_err_q;
`else
  assign STACK_ERR = 1'b0;
`endif

  // Debug-only latches and the unused upper ALU half.
  logic unused_bits;
  assign unused_bits = &{1'b0, ALU_IN[31:16], opt_q, cond_q, npc_q, (STACK_DEPTH > 0)};

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// tb_mem_access : scoreboard bench for mem_access (writeback and redirect
// expectations queued at issue, popped when WB_EN / PC_LOAD appear).
module tb_mem_access;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [31:0] ALU_IN = '0;
  logic [4:0]  OPCD_IN = '0;
  logic [4:0]  ADDR_REG_IN = '0;
  logic        OPT_BIT_IN = 1'b0;
  logic        COND_IN = 1'b0;
  logic [15:0] NPC_IN = '0;
  logic [15:0] STORE_DATA = '0;
  logic [15:0] MEM_RDATA = '0;
  logic        MEM_ACK = 1'b0;
  logic        BUSY, MEM_REQ, MEM_WE, WB_EN, PC_LOAD, DONE, STACK_ERR;
  logic [15:0] MEM_ADDR, MEM_WDATA, WB_DATA, PC_TARGET;
  logic [4:0]  WB_ADDR;
  logic [2:0]  ESTADO;

  mem_access #(.STACK_DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .ALU_IN(ALU_IN), .OPCD_IN(OPCD_IN),
    .ADDR_REG_IN(ADDR_REG_IN), .OPT_BIT_IN(OPT_BIT_IN), .COND_IN(COND_IN),
    .NPC_IN(NPC_IN), .STORE_DATA(STORE_DATA), .BUSY(BUSY), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .PC_LOAD(PC_LOAD), .PC_TARGET(PC_TARGET), .DONE(DONE), .STACK_ERR(STACK_ERR),
    .ESTADO(ESTADO)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } wb_t;

  wb_t         wb_exp[$];
  logic [15:0] pc_exp[$];
  int checks = 0;
  int errors = 0;

  // Scoreboard: every writeback / redirect must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (WB_EN === 1'b1) begin
      checks++;
      if (wb_exp.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, required no writeback", WB_ADDR, WB_DATA);
      end else begin
        wb_t e;
        e = wb_exp.pop_front();
        if ({WB_ADDR, WB_DATA} !== {e.a, e.d}) begin
          errors++;
          $display("FAIL wb_value: got addr=%0d data=%h, required addr=%0d data=%h", WB_ADDR, WB_DATA, e.a, e.d);
        end
      end
    end
    if (PC_LOAD === 1'b1) begin
      checks++;
      if (pc_exp.size() == 0) begin
        errors++;
        $display("FAIL pc_unexpected: got target=%h, required no redirect", PC_TARGET);
      end else begin
        logic [15:0] t;
        t = pc_exp.pop_front();
        if (PC_TARGET !== t) begin
          errors++;
          $display("FAIL pc_target: got %h, required %h", PC_TARGET, t);
        end
      end
    end
  end

  // Drives one bundle; returns at the negedge following E0 (stage in DISPATCH).
  task automatic drive_bundle(input logic [4:0] op, input logic [31:0] alu, input logic [4:0] rd,
                              input logic [15:0] npc, input logic [15:0] sd, input logic cond);
    @(negedge CLK);
    IN_VALID    = 1'b1;
    OPCD_IN     = op;
    ALU_IN      = alu;
    ADDR_REG_IN = rd;
    NPC_IN      = npc;
    STORE_DATA  = sd;
    OPT_BIT_IN  = ~OPT_BIT_IN;
    @(negedge CLK);
    IN_VALID = 1'b0;
    COND_IN  = cond;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: got BUSY=%b, required 0 within 20 cycles", tag, BUSY);
    end
    checks++;
    if (wb_exp.size() != 0 || pc_exp.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d wb and %0d pc outstanding, required 0", tag, wb_exp.size(), pc_exp.size());
      wb_exp.delete();
      pc_exp.delete();
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({BUSY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, WB_EN, WB_ADDR, WB_DATA, PC_LOAD, PC_TARGET, DONE, STACK_ERR, ESTADO} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b busy=%b done=%b estado=%0d err=%b, required all 0", MEM_REQ, BUSY, DONE, ESTADO, STACK_ERR);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (ESTADO !== 3'd0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got estado=%0d busy=%b, required 0 0", ESTADO, BUSY);
    end
  endtask

  task automatic test_alu();
    int ops[7] = '{2, 3, 4, 5, 6, 7, 9};
    wb_exp.push_back('{a: 5'd5, d: 16'h1234});
    drive_bundle(5'd2, 32'h0001_1234, 5'd5, 16'h0, 16'h0, 1'b0);
    checks++;
    if (ESTADO !== 3'd1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL alu_dispatch: got estado=%0d busy=%b, required 1 1", ESTADO, BUSY);
    end
    // A bundle offered while busy must be dropped.
    IN_VALID = 1'b1; OPCD_IN = 5'd2; ALU_IN = 32'h0000_7777; ADDR_REG_IN = 5'd9;
    @(negedge CLK);
    IN_VALID = 1'b0;
    checks++;
    if (WB_EN !== 1'b1 || DONE !== 1'b1 || ESTADO !== 3'd4) begin
      errors++;
      $display("FAIL alu_latency: got wb_en=%b done=%b estado=%0d, required 1 1 4", WB_EN, DONE, ESTADO);
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL alu_retire: got busy=%b done=%b, required 0 0", BUSY, DONE);
    end
    for (int i = 0; i < 7; i++) begin
      logic [31:0] v;
      logic [4:0]  r;
      v = $urandom;
      r = 5'($urandom_range(0, 31));
      wb_exp.push_back('{a: r, d: v[15:0]});
      drive_bundle(5'(ops[i]), v, r, 16'h0, 16'h0, 1'b0);
      wait_idle("alu_op");
    end
  endtask

  task automatic test_finish_ops();
    logic [4:0] fops[3] = '{5'd8, 5'd15, 5'd20};
    for (int i = 0; i < 3; i++) begin
      drive_bundle(fops[i], 32'h0000_0ABC, 5'd3, 16'h0, 16'h0, 1'b1);
      @(negedge CLK);
      checks++;
      if (DONE !== 1'b1 || ESTADO !== 3'd6 || WB_EN !== 1'b0) begin
        errors++;
        $display("FAIL finish_op%0d: got done=%b estado=%0d wb_en=%b, required 1 6 0", fops[i], DONE, ESTADO, WB_EN);
      end
      wait_idle("finish_op");
    end
  endtask

  task automatic test_lw();
    wb_exp.push_back('{a: 5'd7, d: 16'hBEEF});
    drive_bundle(5'd0, 32'h0000_0040, 5'd7, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h0040 || WB_EN !== 1'b0) begin
        errors++;
        $display("FAIL lw_wait%0d: got req=%b we=%b addr=%h wb_en=%b, required 1 0 0040 0", i, MEM_REQ, MEM_WE, MEM_ADDR, WB_EN);
      end
    end
    MEM_ACK = 1'b1; MEM_RDATA = 16'hBEEF;
    @(negedge CLK);
    MEM_ACK = 1'b0; MEM_RDATA = 16'h0;
    checks++;
    if (WB_EN !== 1'b1 || MEM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL lw_complete: got wb_en=%b req=%b, required 1 0", WB_EN, MEM_REQ);
    end
    wait_idle("lw");
    // Acknowledge in the cycle the request rises: three-cycle load.
    wb_exp.push_back('{a: 5'd12, d: 16'h5A5A});
    drive_bundle(5'd0, 32'h0000_0123, 5'd12, 16'h0, 16'h0, 1'b0);
    @(negedge CLK);
    checks++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== 16'h0123) begin
      errors++;
      $display("FAIL lw_fast_req: got req=%b addr=%h, required 1 0123", MEM_REQ, MEM_ADDR);
    end
    MEM_ACK = 1'b1; MEM_RDATA = 16'h5A5A;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    checks++;
    if (WB_EN !== 1'b1) begin
      errors++;
      $display("FAIL lw_fast_latency: got wb_en=%b, required 1", WB_EN);
    end
    wait_idle("lw_fast");
  endtask

  task automatic test_sw();
    drive_bundle(5'd1, 32'h0000_0010, 5'd4, 16'h0, 16'hA5A5, 1'b0);
    @(negedge CLK);
    checks++;
    if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== 16'h0010 || MEM_WDATA !== 16'hA5A5) begin
      errors++;
      $display("FAIL sw_request: got req=%b we=%b addr=%h wdata=%h, required 1 1 0010 a5a5", MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    MEM_ACK = 1'b1;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    checks++;
    if (DONE !== 1'b1 || WB_EN !== 1'b0 || MEM_REQ !== 1'b0) begin
      errors++;
      $display("FAIL sw_done: got done=%b wb_en=%b req=%b, required 1 0 0", DONE, WB_EN, MEM_REQ);
    end
    wait_idle("sw");
  endtask

  task automatic test_branch();
    drive_bundle(5'd12, 32'h0000_0400, 5'd0, 16'h0, 16'h0, 1'b0);
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b1 || PC_LOAD !== 1'b0 || ESTADO !== 3'd6) begin
      errors++;
      $display("FAIL brlf_not_taken: got done=%b pc_load=%b estado=%0d, required 1 0 6", DONE, PC_LOAD, ESTADO);
    end
    wait_idle("brlf");
    pc_exp.push_back(16'h0200);
    drive_bundle(5'd11, 32'h0000_0200, 5'd0, 16'h0, 16'h0, 1'b1);
    @(negedge CLK);
    checks++;
    if (PC_LOAD !== 1'b1 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL jpc_taken: got pc_load=%b done=%b, required 1 1", PC_LOAD, DONE);
    end
    wait_idle("jpc");
    pc_exp.push_back(16'hC0DE);
    drive_bundle(5'd10, 32'hFFFF_C0DE, 5'd0, 16'h0, 16'h0, 1'b1);
    wait_idle("jr");
  endtask

  task automatic test_call_ret();
    apply_reset();
    pc_exp.push_back(16'h0300);
    drive_bundle(5'd13, 32'h0000_0300, 5'd0, 16'h0011, 16'h0, 1'b0);
    wait_idle("call");
`ifdef CALL_STACK_EN
    pc_exp.push_back(16'h0011);
    drive_bundle(5'd14, 32'h0000_0000, 5'd0, 16'h0, 16'h0, 1'b0);
    wait_idle("ret");
`else
    drive_bundle(5'd14, 32'h0000_0000, 5'd0, 16'h0, 16'h0, 1'b0);
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b1 || PC_LOAD !== 1'b0 || ESTADO !== 3'd6) begin
      errors++;
      $display("FAIL ret_nostack: got done=%b pc_load=%b estado=%0d, required 1 0 6", DONE, PC_LOAD, ESTADO);
    end
    wait_idle("ret");
`endif
    checks++;
    if (STACK_ERR !== 1'b0) begin
      errors++;
      $display("FAIL call_ret_err: got %b, required 0", STACK_ERR);
    end
  endtask

`ifdef CALL_STACK_EN
  task automatic test_stack_limits();
    apply_reset();
    pc_exp.push_back(16'h0000);
    drive_bundle(5'd14, 32'h0000_1111, 5'd0, 16'h0, 16'h0, 1'b0);
    wait_idle("ret_empty");
    checks++;
    if (STACK_ERR !== 1'b1) begin
      errors++;
      $display("FAIL underflow_err: got %b, required 1", STACK_ERR);
    end
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      pc_exp.push_back(16'h2000 + 16'(i));
      drive_bundle(5'd13, 32'h2000 + 32'(i), 5'd0, 16'h1000 + 16'(i), 16'h0, 1'b0);
      wait_idle("call_n");
      if (i >= 7) begin
        checks++;
        if (STACK_ERR !== (i == 8)) begin
          errors++;
          $display("FAIL overflow_err_call%0d: got %b, required %b", i, STACK_ERR, (i == 8));
        end
      end
    end
    for (int i = 7; i >= 0; i--) begin
      pc_exp.push_back(16'h1000 + 16'(i));
      drive_bundle(5'd14, 32'h0, 5'd0, 16'h0, 16'h0, 1'b0);
      wait_idle("ret_n");
    end
    pc_exp.push_back(16'h0000);
    drive_bundle(5'd14, 32'h0000_2222, 5'd0, 16'h0, 16'h0, 1'b0);
    wait_idle("ret_drained");
  endtask
`else
  task automatic test_stack_limits();
    for (int i = 0; i < 9; i++) begin
      pc_exp.push_back(16'h2000 + 16'(i));
      drive_bundle(5'd13, 32'h2000 + 32'(i), 5'd0, 16'h1000 + 16'(i), 16'h0, 1'b0);
      wait_idle("call_n");
    end
    checks++;
    if (STACK_ERR !== 1'b0) begin
      errors++;
      $display("FAIL nostack_err: got %b, required 0", STACK_ERR);
    end
  endtask
`endif

  task automatic test_back_to_back();
    wb_exp.push_back('{a: 5'd1, d: 16'h1111});
    wb_exp.push_back('{a: 5'd2, d: 16'h2222});
    drive_bundle(5'd2, 32'h0000_1111, 5'd1, 16'h0, 16'h0, 1'b0);
    // Second bundle held through the DONE cycle; only the following cycle accepts it.
    IN_VALID = 1'b1; OPCD_IN = 5'd3; ALU_IN = 32'h0000_2222; ADDR_REG_IN = 5'd2;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    checks++;
    if (ESTADO !== 3'd1) begin
      errors++;
      $display("FAIL b2b_accept: got estado=%0d, required 1", ESTADO);
    end
    wait_idle("b2b");
  endtask

  task automatic test_reset_midflight();
    drive_bundle(5'd0, 32'h0000_0080, 5'd6, 16'h0, 16'h0, 1'b0);
    @(negedge CLK);
    checks++;
    if (MEM_REQ !== 1'b1) begin
      errors++;
      $display("FAIL midrst_req: got %b, required 1", MEM_REQ);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (MEM_REQ !== 1'b0 || ESTADO !== 3'd0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got req=%b estado=%0d busy=%b, required 0 0 0", MEM_REQ, ESTADO, BUSY);
    end
    @(negedge CLK);
    RST = 1'b1;
    MEM_ACK = 1'b1; MEM_RDATA = 16'hDEAD;
    repeat (2) @(negedge CLK);
    checks++;
    if (WB_EN !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late_ack: got wb_en=%b busy=%b, required 0 0", WB_EN, BUSY);
    end
    MEM_ACK = 1'b0;
    wait_idle("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_finish_ops();
    test_lw();
    test_sw();
    test_branch();
    test_call_ret();
    test_stack_limits();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
